softusb_pmem_loader: RTL and testbench

//  Wishbone bootstrap loader in the sys_clk domain, upstream of the softusb RAM slave port.
//  On a start pulse it copies COUNT 32-bit words from a source Wishbone region (e.g. flash) into softusb program memory.
//  It holds the softusb CPU in reset (cpu_hold) for the whole copy and reports done/error plus a 16-bit checksum.

---
 rtl/softusb_pmem_loader.sv | 183 ++++++++++++++++++
 tb/tb_softusb_pmem_loader.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/softusb_pmem_loader.sv
// softusb_pmem_loader: copies a block of 32-bit words from a source Wishbone
// region into softusb program memory, holding the softusb CPU in reset for
// the duration of the copy. One word moves at a time: read it, then write it.
module softusb_pmem_loader #(
  parameter int          CNT_W    = 11,
  parameter logic [31:0] DST_BASE = 32'h00000000,
  parameter int          TIMEOUT  = 255
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [31:0]      src_base,
  input  logic [CNT_W:0]   count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [15:0]      checksum,
  output logic             cpu_hold,
  output logic [31:0]      s_adr_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  input  logic [31:0]      s_dat_i,
  input  logic             s_ack_i,
  input  logic             s_err_i,
  output logic [31:0]      d_adr_o,
  output logic [31:0]      d_dat_o,
  output logic [3:0]       d_sel_o,
  output logic             d_cyc_o,
  output logic             d_stb_o,
  output logic             d_we_o,
  input  logic             d_ack_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

  // Largest job the index can address; larger requests are clamped to it.
  localparam logic [CNT_W:0] MAX_COUNT = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0] ONE       = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [7:0]     TMO_LIMIT = 8'(TIMEOUT);

  state_t          state_reg, state_next;
  logic [31:0]     src_reg;
  logic [31:0]     data_reg;
  logic [CNT_W:0]  count_reg;
  logic [CNT_W:0]  idx_reg;
  logic [15:0]     checksum_reg;
  logic            error_reg;
  logic            done_reg;
  logic [7:0]      tmo_reg;

  logic [CNT_W:0]  count_clamped;
  logic [CNT_W:0]  idx_inc;
  logic            tmo_hit;

  assign count_clamped = (count > MAX_COUNT) ? MAX_COUNT : count;
  assign idx_inc       = idx_reg + ONE;
  assign tmo_hit       = (tmo_reg == TMO_LIMIT);

  // done is registered out of FIN, so the CPU stays held through the done
  // cycle itself; busy drops as soon as FIN is left.
  assign busy     = (state_reg != IDLE);
  assign cpu_hold = busy | done_reg;
  assign done     = done_reg;
  assign error    = error_reg;
  assign checksum = checksum_reg;
  assign d_sel_o  = 4'hF;

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and bus outputs; strobes are decoded from the state so that
  // leaving READ/WRITE on an ack drops the strobe on that same edge, which
  // guarantees a low-strobe cycle between consecutive RAM writes.
  always_comb begin
    state_next = state_reg;
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_adr_o    = 32'h0;
    d_cyc_o    = 1'b0;
    d_stb_o    = 1'b0;
    d_we_o     = 1'b0;
    d_adr_o    = 32'h0;
    d_dat_o    = 32'h0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (count_clamped == '0) ? FIN : READ;
        end
      end
      READ: begin
        s_cyc_o = 1'b1;
        s_stb_o = 1'b1;
        s_adr_o = src_reg + (32'(idx_reg) << 2);
        if (s_err_i) begin
          state_next = FIN;
        end else if (s_ack_i) begin
          state_next = WRITE;
        end else if (tmo_hit) begin
          state_next = FIN;
        end
      end
      WRITE: begin
        d_cyc_o = 1'b1;
        d_stb_o = 1'b1;
        d_we_o  = 1'b1;
        d_adr_o = DST_BASE + (32'(idx_reg) << 2);
        d_dat_o = data_reg;
        if (d_ack_i) begin
          state_next = (idx_inc == count_reg) ? FIN : READ;
        end else if (tmo_hit) begin
          state_next = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Job datapath: latched parameters, word index, data buffer, checksum,
  // sticky error, done pulse and the per-phase ack timeout counter.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      src_reg      <= 32'h0;
      data_reg     <= 32'h0;
      count_reg    <= '0;
      idx_reg      <= '0;
      checksum_reg <= 16'h0;
      error_reg    <= 1'b0;
      done_reg     <= 1'b0;
      tmo_reg      <= 8'h0;
    end else begin
      done_reg <= (state_reg == FIN);

      if (state_next != state_reg) begin
        tmo_reg <= 8'h0;
      end else if (state_reg == READ || state_reg == WRITE) begin
        tmo_reg <= tmo_reg + 8'h1;
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            src_reg      <= src_base;
            count_reg    <= count_clamped;
            idx_reg      <= '0;
            checksum_reg <= 16'h0;
            error_reg    <= 1'b0;
          end
        end
        READ: begin
          if (s_err_i) begin
            error_reg <= 1'b1;
          end else if (s_ack_i) begin
            data_reg <= s_dat_i;
          end else if (tmo_hit) begin
            error_reg <= 1'b1;
          end
        end
        WRITE: begin
          if (d_ack_i) begin
            checksum_reg <= checksum_reg + data_reg[15:0];
            idx_reg      <= idx_inc;
          end else if (tmo_hit) begin
            error_reg <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softusb_pmem_loader.sv
// Testbench for softusb_pmem_loader: behavioural source slave and program RAM,
// bus-rule monitors, and directed jobs checked against expected images.
module tb_softusb_pmem_loader;

  localparam int CNT_W = 11;
  localparam int NW    = 2048;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             start;
  logic [31:0]      src_base;
  logic [CNT_W:0]   count;
  logic             busy, done, error, cpu_hold;
  logic [15:0]      checksum;
  logic [31:0]      s_adr_o;
  logic             s_cyc_o, s_stb_o;
  logic [31:0]      s_dat_i = 32'h0;
  logic             s_ack_i = 1'b0;
  logic             s_err_i = 1'b0;
  logic [31:0]      d_adr_o, d_dat_o;
  logic [3:0]       d_sel_o;
  logic             d_cyc_o, d_stb_o, d_we_o;
  logic             d_ack_i = 1'b0;

  softusb_pmem_loader #(.CNT_W(CNT_W), .DST_BASE(32'h0), .TIMEOUT(255)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .src_base(src_base),
    .count(count), .busy(busy), .done(done), .error(error), .checksum(checksum),
    .cpu_hold(cpu_hold), .s_adr_o(s_adr_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .d_adr_o(d_adr_o),
    .d_dat_o(d_dat_o), .d_sel_o(d_sel_o), .d_cyc_o(d_cyc_o), .d_stb_o(d_stb_o),
    .d_we_o(d_we_o), .d_ack_i(d_ack_i)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;
  int ecnt     = 0;

  // Source configuration, written only by the stimulus block.
  logic [31:0] cur_base  = 32'h0;
  logic [31:0] seed      = 32'h0;
  bit          fixed_mode = 1'b0;
  bit          rand_wait  = 1'b0;
  int          src_mode   = 0;    // 0 normal, 1 error on err_word, 2 never ack
  int          err_word   = 0;
  bit          clr_tog    = 1'b0;

  // Program RAM image and per-word write counts, owned by the responder.
  logic [31:0] ram [NW];
  int          wcnt [NW];
  bit          clr_seen = 1'b0;
  int          s_wait = 1;
  bit          d_seen = 1'b0;
  int          s_stb_cyc = 0, d_stb_cyc = 0;
  int          bus_viol = 0, gap_viol = 0, adr_viol = 0, oor_writes = 0;
  bit          prev_s_stb = 1'b0, prev_d_stb = 1'b0;
  logic [31:0] prev_s_adr = 32'h0, prev_d_adr = 32'h0, prev_d_dat = 32'h0;

  always @(posedge sys_clk) ecnt++;

  // Contents of the source region: word i of a job starting at base.
  function automatic logic [31:0] src_word(input logic [31:0] base, input int i);
    logic [31:0] a;
    if (fixed_mode) return 32'(i + 1) * 32'h1111;
    a = base + 32'(i) * 32'd4;
    return (a * 32'h9E3779B1) ^ seed;
  endfunction

  // Responders and bus monitors, evaluated mid-cycle on the falling edge.
  always @(negedge sys_clk) begin : resp
    int wi;
    logic [31:0] off;
    if (clr_tog != clr_seen) begin
      for (int i = 0; i < NW; i++) begin
        ram[i]  = 32'h0;
        wcnt[i] = 0;
      end
      clr_seen = clr_tog;
    end
    // monitors
    if (s_stb_o) s_stb_cyc++;
    if (d_stb_o) d_stb_cyc++;
    if (s_stb_o && d_stb_o) bus_viol++;
    if (d_stb_o && (!d_we_o || !d_cyc_o || d_sel_o != 4'hF)) bus_viol++;
    if (s_stb_o && !s_cyc_o) bus_viol++;
    if (d_stb_o && d_ack_i) gap_viol++;
    if (s_stb_o && prev_s_stb && s_adr_o != prev_s_adr) adr_viol++;
    if (d_stb_o && prev_d_stb && (d_adr_o != prev_d_adr || d_dat_o != prev_d_dat)) adr_viol++;
    prev_s_stb = s_stb_o;  prev_s_adr = s_adr_o;
    prev_d_stb = d_stb_o;  prev_d_adr = d_adr_o;  prev_d_dat = d_dat_o;
    // source slave: ack/err after (wait + 1) strobe cycles
    if (s_stb_o) begin
      if (s_wait == 0) begin
        off = s_adr_o - cur_base;
        wi  = int'(off >> 2);
        if (src_mode == 1 && wi == err_word) begin
          s_err_i = 1'b1;
        end else if (src_mode != 2) begin
          s_ack_i = 1'b1;
          s_dat_i = src_word(cur_base, wi);
        end
      end else begin
        s_wait--;
      end
    end else begin
      s_ack_i = 1'b0;
      s_err_i = 1'b0;
      s_wait  = (rand_wait ? int'($urandom_range(0, 3)) : 0) + 1;
    end
    // program RAM: ack one cycle after strobe, one write per ack
    if (d_stb_o && !d_ack_i) begin
      if (!d_seen) begin
        d_seen = 1'b1;
      end else begin
        d_ack_i = 1'b1;
        d_seen  = 1'b0;
        if (d_adr_o < 32'(NW * 4)) begin
          wi = int'(d_adr_o >> 2);
          ram[wi] = d_dat_o;
          wcnt[wi]++;
        end else begin
          oor_writes++;
        end
      end
    end else begin
      d_ack_i = 1'b0;
      d_seen  = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Expected checksum: low halves of the first n source words.
  function automatic logic [15:0] exp_sum(input logic [31:0] base, input int n);
    logic [15:0] s = 16'h0;
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = src_word(base, i);
      s = s + w[15:0];
    end
    return s;
  endfunction

  // Words that differ from "first n words copied exactly once, rest untouched".
  function automatic int ram_errors(input logic [31:0] base, input int n);
    int e = 0;
    for (int i = 0; i < NW; i++) begin
      if (i < n) begin
        if (wcnt[i] != 1 || ram[i] !== src_word(base, i)) e++;
      end else if (wcnt[i] != 0) begin
        e++;
      end
    end
    return e;
  endfunction

  task automatic clear_ram();
    clr_tog = ~clr_tog;
    @(negedge sys_clk);
    @(negedge sys_clk);
  endtask

  // Wait for done, counting cycles where cpu_hold was low during the job.
  task automatic wait_done(input int t0, input int maxcyc, output int lat,
                           output int hold_bad, output bit got);
    got = 1'b0; lat = -1; hold_bad = 0;
    for (int c = 0; c < maxcyc; c++) begin
      @(negedge sys_clk);
      start = 1'b0;
      if (!cpu_hold) hold_bad++;
      if (done) begin
        got = 1'b1;
        lat = ecnt - t0;
        break;
      end
    end
  endtask

  task automatic run_job(input logic [31:0] base, input logic [CNT_W:0] n, input int maxcyc,
                         output int lat, output int hold_bad, output bit got);
    int t0;
    cur_base = base;
    @(negedge sys_clk);
    t0 = ecnt;
    start = 1'b1; src_base = base; count = n;
    wait_done(t0, maxcyc, lat, hold_bad, got);
  endtask

  initial begin
    int lat, hold_bad, s0, d0, t0, busy_seen, dones;
    bit got, found;
    logic [31:0] base;

    sys_rst = 1'b1; start = 1'b0; src_base = 32'h0; count = '0;
    repeat (3) @(negedge sys_clk);
    check("rst_ctrl", 32'({busy, done, error, cpu_hold, s_cyc_o, s_stb_o, d_cyc_o, d_stb_o, d_we_o}), 32'h0);
    check("rst_checksum", 32'(checksum), 32'h0);
    check("rst_s_adr", s_adr_o, 32'h0);
    check("rst_d_adr", d_adr_o, 32'h0);
    check("rst_d_dat", d_dat_o, 32'h0);
    check("rst_d_sel", 32'(d_sel_o), 32'hF);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // T1: four fixed words, zero-wait source
    fixed_mode = 1'b1; rand_wait = 1'b0; src_mode = 0;
    clear_ram();
    run_job(32'h0010_0000, 12'd4, 100, lat, hold_bad, got);
    $display("T1 count=4 lat=%0d checksum=%h error=%0d", lat, checksum, error);
    check("t1_latency", 32'(lat), 32'd18);
    check("t1_error", 32'(error), 32'h0);
    check("t1_checksum", 32'(checksum), 32'h0000AAAA);
    check("t1_cpu_hold", 32'(hold_bad), 32'h0);
    check("t1_ram", 32'(ram_errors(32'h0010_0000, 4)), 32'h0);
    @(negedge sys_clk);
    check("t1_after", 32'({busy, cpu_hold, done}), 32'h0);

    // T2: empty job
    s0 = s_stb_cyc; d0 = d_stb_cyc;
    run_job(32'h0010_0000, 12'd0, 20, lat, hold_bad, got);
    $display("T2 count=0 lat=%0d", lat);
    check("t2_latency", 32'(lat), 32'd2);
    check("t2_cpu_hold", 32'(hold_bad), 32'h0);
    check("t2_strobes", 32'((s_stb_cyc - s0) + (d_stb_cyc - d0)), 32'h0);
    check("t2_checksum", 32'(checksum), 32'h0);
    @(negedge sys_clk);
    check("t2_after", 32'({busy, cpu_hold, done}), 32'h0);

    // T3: source error on word 2 of 5
    fixed_mode = 1'b0; seed = $urandom; rand_wait = 1'b1; src_mode = 1; err_word = 2;
    base = $urandom & 32'hFFFF_FFFC;
    clear_ram();
    run_job(base, 12'd5, 200, lat, hold_bad, got);
    $display("T3 err@2 done=%0d error=%0d checksum=%h", got, error, checksum);
    check("t3_done", 32'(got), 32'h1);
    check("t3_error", 32'(error), 32'h1);
    check("t3_checksum", 32'(checksum), 32'(exp_sum(base, 2)));
    check("t3_ram", 32'(ram_errors(base, 2)), 32'h0);

    // T4: source never acks; done 257 cycles after READ entry
    src_mode = 2; rand_wait = 1'b0;
    clear_ram();
    run_job(base, 12'd3, 400, lat, hold_bad, got);
    $display("T4 noack lat=%0d error=%0d", lat, error);
    check("t4_latency", 32'(lat), 32'd258);
    check("t4_error", 32'(error), 32'h1);
    check("t4_ram", 32'(ram_errors(base, 0)), 32'h0);
    @(negedge sys_clk);
    check("t4_s_stb_low", 32'({s_cyc_o, s_stb_o}), 32'h0);

    // T5a: second start while busy is ignored
    src_mode = 0; seed = $urandom;
    base = $urandom & 32'hFFFF_FFFC;
    clear_ram();
    cur_base = base;
    @(negedge sys_clk);
    t0 = ecnt;
    start = 1'b1; src_base = base; count = 12'd3;
    repeat (4) begin
      @(negedge sys_clk);
      start = 1'b0;
    end
    check("t5_busy_mid", 32'(busy), 32'h1);
    start = 1'b1; src_base = base + 32'h400; count = 12'd9;
    wait_done(t0, 100, lat, hold_bad, got);
    busy_seen = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (busy) busy_seen++;
    end
    $display("T5a lat=%0d checksum=%h busy_after=%0d", lat, checksum, busy_seen);
    check("t5_latency", 32'(lat), 32'd14);
    check("t5_checksum", 32'(checksum), 32'(exp_sum(base, 3)));
    check("t5_ram", 32'(ram_errors(base, 3)), 32'h0);
    check("t5_no_second_job", 32'(busy_seen), 32'h0);

    // T5b: reset during a write after at least one word was summed
    @(negedge sys_clk);
    start = 1'b1; src_base = base; count = 12'd6;
    found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge sys_clk);
      start = 1'b0;
      if (d_stb_o && checksum != 16'h0) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_reached_write", 32'(found), 32'h1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("t5_rst_ctrl", 32'({busy, done, error, cpu_hold, s_cyc_o, s_stb_o, d_cyc_o, d_stb_o, d_we_o}), 32'h0);
    check("t5_rst_checksum", 32'(checksum), 32'h0);
    check("t5_rst_adr", s_adr_o | d_adr_o | d_dat_o, 32'h0);
    sys_rst = 1'b0;
    dones = 0;
    repeat (10) begin
      @(negedge sys_clk);
      if (done || busy) dones++;
    end
    $display("T5b reset mid-write found=%0d activity_after=%0d", found, dones);
    check("t5_no_done", 32'(dones), 32'h0);

    // T6: full 2048-word copy with random source wait states
    seed = $urandom; rand_wait = 1'b1;
    base = $urandom & 32'hFFFF_FFFC;
    clear_ram();
    run_job(base, 12'd2048, 40000, lat, hold_bad, got);
    $display("T6 count=2048 done=%0d lat=%0d checksum=%h", got, lat, checksum);
    check("t6_done", 32'(got), 32'h1);
    check("t6_error", 32'(error), 32'h0);
    check("t6_checksum", 32'(checksum), 32'(exp_sum(base, 2048)));
    check("t6_ram", 32'(ram_errors(base, 2048)), 32'h0);
    check("t6_cpu_hold", 32'(hold_bad), 32'h0);

    // T7: oversized count clamps to 2048 words
    seed = $urandom; rand_wait = 1'b0;
    base = $urandom & 32'hFFFF_FFFC;
    clear_ram();
    run_job(base, 12'hFFF, 20000, lat, hold_bad, got);
    $display("T7 count=0xFFF lat=%0d checksum=%h", lat, checksum);
    check("t7_latency", 32'(lat), 32'd8194);
    check("t7_ram", 32'(ram_errors(base, 2048)), 32'h0);
    check("t7_checksum", 32'(checksum), 32'(exp_sum(base, 2048)));

    // T8: short random jobs
    rand_wait = 1'b1;
    for (int j = 0; j < 3; j++) begin
      int n;
      n = int'($urandom_range(1, 12));
      seed = $urandom;
      base = $urandom & 32'hFFFF_FFFC;
      clear_ram();
      run_job(base, 12'(n), 200, lat, hold_bad, got);
      $display("T8.%0d count=%0d done=%0d checksum=%h", j, n, got, checksum);
      check("t8_error", 32'({got, error}), 32'h2);
      check("t8_checksum", 32'(checksum), 32'(exp_sum(base, n)));
      check("t8_ram", 32'(ram_errors(base, n)), 32'h0);
    end

    check("bus_overlap_or_sel", 32'(bus_viol), 32'h0);
    check("strobe_gap", 32'(gap_viol), 32'h0);
    check("adr_dat_stable", 32'(adr_viol), 32'h0);
    check("write_range", 32'(oor_writes), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
